stream_master_tx: RTL and testbench

Transmitting end of the valid/ready word handshake: buffers words from a local producer in a small FIFO and sends them as a counted burst to a downstream slave. Drives `valid`/`data`, samples `ready`, and obeys the source-side rules: once `valid` is high, it and `data` stay stable until a handshake. Sits between producer logic and any slave receiver on the same handshake.

---
 rtl/stream_master_tx.sv | 171 +++++++++++++++++
 tb/tb_stream_master_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_master_tx.sv
// Circular word buffer with occupancy count; a write while full is accepted only alongside a pop.
// Zero-latency head read; push and pop take effect at the clock edge.
// No backpressure of its own: the owner gates push on full and pop on empty.
module stream_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;

    // A pop in the same cycle frees the slot the write needs.
    assign push_ok = push && (!full || pop);
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Valid/ready source: buffers producer words and sends a counted burst of them downstream.
// First beat one cycle after start (FIFO non-empty), then one beat per cycle; done one cycle after the last beat.
// ready=0 freezes valid/data; producer writes are dropped while full unless a pop frees a slot.
module stream_master_tx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    input  logic              start,
    input  logic [7:0]        burst_len,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              ready
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        beats_left;
    logic              hs;
    logic              load;
    logic              done_nxt;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign hs   = valid && ready;
    assign busy = (state == SEND);

    stream_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH),
        .CW    (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (load),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (full),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A load is allowed only if beats remain once the word now in flight is counted,
    // so a burst never drains words that belong to the next one.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != 8'd0) begin
                        state_nxt = SEND;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                load = !fifo_empty && (!valid || (hs && (beats_left > 8'd1)));
                if (hs && (beats_left == 8'd1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            data       <= '0;
            beats_left <= 8'd0;
            done       <= 1'b0;
        end else begin
            done <= done_nxt;
            if ((state == IDLE) && start && (burst_len != 8'd0)) begin
                beats_left <= burst_len;
            end else if ((state == SEND) && hs) begin
                beats_left <= beats_left - 8'd1;
            end
            // The final handshake never coincides with a load, so valid clears there.
            if (load) begin
                valid <= 1'b1;
                data  <= fifo_head;
            end else if (hs) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_master_tx.sv
// Directed bench for stream_master_tx: bursts, ready stalls, FIFO bubbles, full/drop, short and zero bursts, reset mid-burst.
module tb_stream_master_tx;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic [2:0]  count;
    logic        start;
    logic [7:0]  burst_len;
    logic        busy;
    logic        done;
    logic        valid;
    logic [31:0] data;
    logic        ready;

    int tests;
    int failed;

    logic [31:0] exp_q[$];
    logic [31:0] wr_q[$];
    int          wr_delay;
    logic        bub;

    stream_master_tx #(.DATA_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .count     (count),
        .start     (start),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .data      (data),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_word(input logic [31:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    // Drives ready from a repeating pattern, feeds queued producer writes from cycle wr_delay,
    // and checks every accepted beat against exp_q and every stalled cycle for stability.
    task automatic run_burst(input string tag, input logic [7:0] pat, input int plen,
                             input int nbeats, output logic bubble);
        logic        pv;
        logic [31:0] pd;
        logic [31:0] ev;
        logic        got_done;
        int          beats;
        got_done = 1'b0;
        beats    = 0;
        bubble   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            ready = pat[c % plen];
            if ((c >= wr_delay) && (wr_q.size() > 0)) begin
                wr_en   = 1'b1;
                wr_data = wr_q.pop_front();
            end else begin
                wr_en = 1'b0;
            end
            pv = valid;
            pd = data;
            step();
            if (pv && ready) begin
                beats++;
                ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                chk({tag, "_beat_data"}, pd, ev);
            end else if (pv) begin
                chk({tag, "_stall_valid"}, {31'd0, valid}, 32'd1);
                chk({tag, "_stall_data"}, data, pd);
            end
            if (done) begin
                got_done = 1'b1;
                chk({tag, "_end_valid"}, {31'd0, valid}, 32'd0);
                chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
                break;
            end
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (!valid && (beats > 0)) begin
                bubble = 1'b1;
            end
        end
        wr_en = 1'b0;
        ready = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
        chk({tag, "_beat_count"}, beats, nbeats);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 32'd0;
        start     = 1'b0;
        burst_len = 8'd0;
        ready     = 1'b0;
        wr_delay  = 0;

        // Reset state
        step();
        step();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        rst_n = 1'b1;
        step();

        // Four-beat burst with ready held high: check cycle-exact timing
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        push_word(32'h44);
        chk("t1_count4", {29'd0, count}, 32'd4);
        chk("t1_full", {31'd0, full}, 32'd1);
        ready     = 1'b1;
        start     = 1'b1;
        burst_len = 8'd4;
        step();
        start = 1'b0;
        chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
        chk("t1_valid_after_start", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_valid", {31'd0, valid}, 32'd1);
            chk("t1_data", data, 32'h11 * (i + 1));
        end
        step();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_valid_end", {31'd0, valid}, 32'd0);
        chk("t1_count0", {29'd0, count}, 32'd0);
        step();
        chk("t1_done_once", {31'd0, done}, 32'd0);
        ready = 1'b0;

        // Same burst with ready toggling 1,0,0,1
        push_word(32'hA1);
        push_word(32'hA2);
        push_word(32'hA3);
        push_word(32'hA4);
        start     = 1'b1;
        burst_len = 8'd4;
        step();
        start = 1'b0;
        exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        run_burst("t2", 8'b0000_1001, 4, 4, bub);
        chk("t2_count0", {29'd0, count}, 32'd0);

        // Six beats with only two preloaded; the rest arrive late
        push_word(32'hB1);
        push_word(32'hB2);
        start     = 1'b1;
        burst_len = 8'd6;
        step();
        start    = 1'b0;
        exp_q    = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6};
        wr_q     = '{32'hB3, 32'hB4, 32'hB5, 32'hB6};
        wr_delay = 5;
        run_burst("t3", 8'h01, 1, 6, bub);
        chk("t3_bubble", {31'd0, bub}, 32'd1);
        chk("t3_count0", {29'd0, count}, 32'd0);

        // Fill, drop a write while full, then write and pop together
        push_word(32'hC1);
        push_word(32'hC2);
        push_word(32'hC3);
        push_word(32'hC4);
        push_word(32'hC5);
        chk("t4_full", {31'd0, full}, 32'd1);
        chk("t4_count_after_drop", {29'd0, count}, 32'd4);
        start     = 1'b1;
        burst_len = 8'd1;
        step();
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'hC6;
        step();
        wr_en = 1'b0;
        chk("t4_count_wr_pop", {29'd0, count}, 32'd4);
        chk("t4_head_c1", data, 32'hC1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_count_keep", {29'd0, count}, 32'd4);

        // Two-beat burst from four queued words; a start during SEND is ignored
        start     = 1'b1;
        burst_len = 8'd2;
        step();
        burst_len = 8'd3;
        step();
        start = 1'b0;
        chk("t5_first_valid", {31'd0, valid}, 32'd1);
        chk("t5_first_data", data, 32'hC2);
        exp_q    = '{32'hC2, 32'hC3};
        wr_delay = 1000;
        run_burst("t5", 8'h01, 1, 2, bub);
        chk("t5_count2", {29'd0, count}, 32'd2);

        // Zero-length burst: done only
        start     = 1'b1;
        burst_len = 8'd0;
        step();
        start = 1'b0;
        chk("t5z_done", {31'd0, done}, 32'd1);
        chk("t5z_busy", {31'd0, busy}, 32'd0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t5z_done_clear", {31'd0, done}, 32'd0);
        chk("t5z_valid", {31'd0, valid}, 32'd0);
        chk("t5z_count", {29'd0, count}, 32'd2);

        // Reset while a word is stalled on the output
        start     = 1'b1;
        burst_len = 8'd2;
        step();
        start = 1'b0;
        step();
        chk("t6_valid_pre", {31'd0, valid}, 32'd1);
        chk("t6_data_pre", data, 32'hC4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_valid", {31'd0, valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_full", {31'd0, full}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        ready = 1'b1;
        step();
        chk("t6_stay_idle", {31'd0, valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
